// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 DIT FFT with valid/ready on both sides.
// Collects 4 samples, computes in 2 registered stages, emits bins 0..3.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_re, in_im          signed input sample (DATA_W)
//   in_last               marks the 4th sample of a frame
//   scale_i               1 = scale frame outputs by 1/4 (taken at sample 0)
//   out_valid/out_ready   output handshake
//   out_re, out_im        signed output bin (DATA_W+2)
//   out_idx, out_last     bin index, high with bin 3
//   frame_err             one-cycle pulse on a framing error
//   busy                  engine holds or is processing a frame
module fft4_stream #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    input  logic                     in_last,
    input  logic                     scale_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W+1:0] out_re,
    output logic signed [DATA_W+1:0] out_im,
    output logic [1:0]               out_idx,
    output logic                     out_last,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int OUT_W = DATA_W + 2;

    typedef enum logic [1:0] {
        COLLECT,
        ST1,
        ST2,
        EMIT
    } state_t;

    state_t state, state_nx;

    logic [1:0] n;
    logic [1:0] k;
    logic       scale;
    logic       ferr;
    logic       acc_in;
    logic       acc_out;

    logic signed [DATA_W-1:0] x_re [4];
    logic signed [DATA_W-1:0] x_im [4];
    logic signed [OUT_W-1:0]  a_re [4];
    logic signed [OUT_W-1:0]  a_im [4];
    logic signed [OUT_W-1:0]  s_re [4];
    logic signed [OUT_W-1:0]  s_im [4];
    logic signed [OUT_W-1:0]  t_re [4];
    logic signed [OUT_W-1:0]  t_im [4];
    logic signed [OUT_W-1:0]  y_re [4];
    logic signed [OUT_W-1:0]  y_im [4];

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT: if (acc_in && n == 2'd3) state_nx = ST1;
            ST1:     state_nx = ST2;
            ST2:     state_nx = EMIT;
            EMIT:    if (acc_out && k == 2'd3) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    // Sample collection and framing check.  A 4th sample is always
    // accepted into the frame; only an early in_last discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n     <= 2'd0;
            scale <= 1'b0;
            ferr  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
            end
        end else begin
            ferr <= 1'b0;
            if (acc_in) begin
                x_re[n] <= in_re;
                x_im[n] <= in_im;
                if (n == 2'd0) scale <= scale_i;
                if (n == 2'd3) begin
                    n    <= 2'd0;
                    ferr <= !in_last;
                end else if (in_last) begin
                    n    <= 2'd0;
                    ferr <= 1'b1;
                end else begin
                    n <= n + 2'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_re[i] = {{2{x_re[i][DATA_W-1]}}, x_re[i]};
            a_im[i] = {{2{x_im[i][DATA_W-1]}}, x_im[i]};
        end
    end

    // Stage 1 butterflies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                s_re[i] <= '0;
                s_im[i] <= '0;
            end
        end else if (state == ST1) begin
            s_re[0] <= a_re[0] + a_re[2];
            s_im[0] <= a_im[0] + a_im[2];
            s_re[2] <= a_re[0] - a_re[2];
            s_im[2] <= a_im[0] - a_im[2];
            s_re[1] <= a_re[1] + a_re[3];
            s_im[1] <= a_im[1] + a_im[3];
            s_re[3] <= a_re[1] - a_re[3];
            s_im[3] <= a_im[1] - a_im[3];
        end
    end

    // Stage 2; multiplying s3 by -j is a swap with negated real part
    always_comb begin
        t_re[0] = s_re[0] + s_re[1];
        t_im[0] = s_im[0] + s_im[1];
        t_re[2] = s_re[0] - s_re[1];
        t_im[2] = s_im[0] - s_im[1];
        t_re[1] = s_re[2] + s_im[3];
        t_im[1] = s_im[2] - s_re[3];
        t_re[3] = s_re[2] - s_im[3];
        t_im[3] = s_im[2] + s_re[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                y_re[i] <= '0;
                y_im[i] <= '0;
            end
        end else if (state == ST2) begin
            for (int i = 0; i < 4; i++) begin
                y_re[i] <= scale ? (t_re[i] >>> 2) : t_re[i];
                y_im[i] <= scale ? (t_im[i] >>> 2) : t_im[i];
            end
        end
    end

    // Bin counter wraps to 0 on the bin-3 handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 2'd0;
        end else if (acc_out) begin
            k <= k + 2'd1;
        end
    end

    assign out_re    = out_valid ? y_re[k] : '0;
    assign out_im    = out_valid ? y_im[k] : '0;
    assign out_idx   = k;
    assign out_last  = out_valid && (k == 2'd3);
    assign frame_err = ferr;
    assign busy      = (state != COLLECT) || (n != 2'd0);

endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: latency, bins, scaling, backpressure,
// framing errors and asynchronous reset during emit.
module tb_fft4_stream;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_re;
    logic signed [15:0] in_im;
    logic               in_last;
    logic               scale_i;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_re;
    logic signed [17:0] out_im;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               frame_err;
    logic               busy;

    int checks = 0;
    int errors = 0;
    int er [4];
    int ei [4];

    fft4_stream #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .scale_i   (scale_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int re, input int im,
                        input logic last, input logic sc);
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        in_last  = last;
        scale_i  = sc;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_bin(input int k);
        chk($sformatf("valid_b%0d", k), out_valid, 1);
        chk($sformatf("idx_b%0d", k), out_idx, k);
        chk($sformatf("re_b%0d", k), out_re, er[k]);
        chk($sformatf("im_b%0d", k), out_im, ei[k]);
        chk($sformatf("last_b%0d", k), out_last, (k == 3) ? 1 : 0);
        chk($sformatf("inrdy_b%0d", k), in_ready, 0);
    endtask

    // Called right after the 4th accepting edge; out_ready must be 1.
    task automatic expect_frame(input string name);
        chk({name, "_lat0"}, out_valid, 0);
        chk({name, "_busy"}, busy, 1);
        step();
        chk({name, "_lat1"}, out_valid, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            check_bin(k);
            step();
        end
        chk({name, "_done_rdy"}, in_ready, 1);
        chk({name, "_done_vld"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        scale_i   = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        #11 rst_n = 1'b1;
        step();

        // impulse at n=0
        send(1, 0, 0, 0);
        chk("busy_mid", busy, 1);
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 1, 0);
        chk("imp_ferr", frame_err, 0);
        chk("imp_st1_rdy", in_ready, 0);
        er = '{1, 1, 1, 1};
        ei = '{0, 0, 0, 0};
        expect_frame("imp");

        // impulse at n=1
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 1, 0);
        er = '{1, 0, -1, 0};
        ei = '{0, -1, 0, 1};
        expect_frame("imp1");

        // DC full scale, unscaled
        send(-32768, 0, 0, 0);
        send(-32768, 0, 0, 0);
        send(-32768, 0, 0, 0);
        send(-32768, 0, 1, 0);
        er = '{-131072, 0, 0, 0};
        ei = '{0, 0, 0, 0};
        expect_frame("dc");

        // DC full scale, scale taken at n=0 then toggled
        send(-32768, 0, 0, 1);
        send(-32768, 0, 0, 0);
        send(-32768, 0, 0, 1);
        send(-32768, 0, 1, 0);
        er = '{-32768, 0, 0, 0};
        expect_frame("dcs");

        // backpressure at bin 1, x = 1,2,3,4
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 0, 0, 0);
        send(4, 0, 1, 0);
        er = '{10, -2, -2, -2};
        ei = '{0, 2, 0, -2};
        step();
        step();
        check_bin(0);
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bin(1);
            step();
        end
        check_bin(1);
        out_ready = 1'b1;
        step();
        check_bin(2);
        step();
        check_bin(3);
        step();
        chk("bp_done_rdy", in_ready, 1);
        chk("bp_done_vld", out_valid, 0);

        // early in_last on 2nd sample
        send(5, 5, 0, 0);
        send(6, 6, 1, 0);
        chk("early_ferr", frame_err, 1);
        chk("early_busy", busy, 0);
        chk("early_rdy", in_ready, 1);
        step();
        chk("early_ferr_off", frame_err, 0);
        chk("early_novld", out_valid, 0);
        step();
        chk("early_novld2", out_valid, 0);
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 1, 0);
        chk("clean_ferr", frame_err, 0);
        er = '{1, 0, -1, 0};
        ei = '{0, -1, 0, 1};
        expect_frame("clean");

        // missing in_last on 4th sample
        send(0, 1, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        chk("nolast_ferr", frame_err, 1);
        er = '{0, 0, 0, 0};
        ei = '{1, 1, 1, 1};
        expect_frame("nolast");

        // async reset at bin 2
        send(1, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 0, 0);
        send(0, 0, 1, 0);
        er = '{1, 1, 1, 1};
        ei = '{0, 0, 0, 0};
        step();
        step();
        step();
        step();
        check_bin(2);
        rst_n = 1'b0;
        #1;
        chk("ar_vld", out_valid, 0);
        chk("ar_idx", out_idx, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ferr", frame_err, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("ar_rdy", in_ready, 1);
        step();
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 0, 0, 0);
        send(4, 0, 1, 0);
        er = '{10, -2, -2, -2};
        ei = '{0, 2, 0, -2};
        expect_frame("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
